// File: rtl/tri_assembler.sv
// Triangle assembler: gathers three vertices into a Triangle3D, optionally culls
// zero-area triangles, and presents the result on a valid/ready output slot.
package tri_pkg;
    localparam int POINT_W = 16;

    typedef struct packed {
        logic signed [POINT_W-1:0] x;
        logic signed [POINT_W-1:0] y;
        logic signed [POINT_W-1:0] z;
    } point3d_t;

    typedef struct packed {
        point3d_t p;
        point3d_t q;
        point3d_t r;
    } Triangle3D;
endpackage

module tri_assembler
    import tri_pkg::*;
#(
    parameter int COORD_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      vtx_valid,
    output logic                      vtx_ready,
    input  logic signed [COORD_W-1:0] vtx_x,
    input  logic signed [COORD_W-1:0] vtx_y,
    input  logic signed [COORD_W-1:0] vtx_z,
    input  logic                      flush,
    input  logic                      cull_en,
    output logic                      tri_valid,
    input  logic                      tri_ready,
    output Triangle3D                 tri_out,
    output logic [CNT_W-1:0]          tri_count,
    output logic [CNT_W-1:0]          cull_count
);
    typedef enum logic [1:0] {V0, V1, V2} state_t;

    state_t   state, next_state;
    point3d_t p_held, q_held, vtx;
    logic     accept, complete, cull, load;

    logic signed [COORD_W:0]     dx_q, dy_q, dx_r, dy_r;
    logic signed [2*COORD_W+1:0] prod_a, prod_b;
    logic signed [2*COORD_W+2:0] area;

    assign vtx       = '{x: vtx_x, y: vtx_y, z: vtx_z};
    assign vtx_ready = (!tri_valid || tri_ready) && !flush;
    assign accept    = vtx_valid && vtx_ready;

    // Operands widened by one bit so the differences and the final area never overflow.
    assign dx_q   = (COORD_W+1)'(q_held.x) - (COORD_W+1)'(p_held.x);
    assign dy_q   = (COORD_W+1)'(q_held.y) - (COORD_W+1)'(p_held.y);
    assign dx_r   = (COORD_W+1)'(vtx.x)    - (COORD_W+1)'(p_held.x);
    assign dy_r   = (COORD_W+1)'(vtx.y)    - (COORD_W+1)'(p_held.y);
    assign prod_a = (2*COORD_W+2)'(dx_q) * (2*COORD_W+2)'(dy_r);
    assign prod_b = (2*COORD_W+2)'(dy_q) * (2*COORD_W+2)'(dx_r);
    assign area   = (2*COORD_W+3)'(prod_a) - (2*COORD_W+3)'(prod_b);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= V0;
        else        state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        complete   = 1'b0;
        unique case (state)
            V0: if (accept) next_state = V1;
            V1: if (accept) next_state = V2;
            V2: if (accept) begin
                next_state = V0;
                complete   = 1'b1;
            end
            default: next_state = V0;
        endcase
        if (flush) next_state = V0;
        cull = complete && cull_en && (area == '0);
        load = complete && !cull;
    end

    // NOTE: datapath registers are reset too, so held vertices and tri_out read as zero after reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            p_held     <= '0;
            q_held     <= '0;
            tri_valid  <= 1'b0;
            tri_out    <= '0;
            tri_count  <= '0;
            cull_count <= '0;
        end else begin
            if (accept && state == V0) p_held <= vtx;
            if (accept && state == V1) q_held <= vtx;
            if (load) begin
                tri_out   <= '{p: p_held, q: q_held, r: vtx};
                tri_valid <= 1'b1;
                tri_count <= tri_count + 1'b1;
            end else if (tri_valid && tri_ready) begin
                tri_valid <= 1'b0;
            end
            if (cull) cull_count <= cull_count + 1'b1;
        end
    end
endmodule

// File: doc/tri_assembler.md
TRI_ASSEMBLER -- requirements
Module: tri_assembler

Interface
REQ-001 SHALL have parameter COORD_W, default 16, signed coordinate width; it SHALL match the Triangle3D point fields.
REQ-002 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-003 SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port vtx_valid  input  1  input vertex present.
REQ-006 SHALL have port vtx_ready  output  1  the block accepts the vertex this cycle.
REQ-007 SHALL have ports vtx_x, vtx_y, vtx_z  input  COORD_W each  signed vertex coordinates.
REQ-008 SHALL have port flush  input  1  discards any partially assembled triangle.
REQ-009 SHALL have port cull_en  input  1  enables zero-area triangle culling.
REQ-010 SHALL have port tri_valid  output  1  tri_out holds a complete triangle.
REQ-011 SHALL have port tri_ready  input  1  downstream (PQ-reorientation stage) accepts tri_out.
REQ-012 SHALL have port tri_out  output  Triangle3D  assembled triangle: p = 1st, q = 2nd, r = 3rd vertex.
REQ-013 SHALL have port tri_count  output  CNT_W  number of triangles emitted; wraps.
REQ-014 SHALL have port cull_count  output  CNT_W  number of triangles culled; wraps.

Function
REQ-015 A vertex SHALL be accepted only on a cycle where vtx_valid and vtx_ready are both high.
REQ-016 vtx_ready SHALL be (!tri_valid || tri_ready) && !flush.
REQ-017 FSM states SHALL be V0 (no vertices held), V1 (p held) and V2 (p, q held).
REQ-018 Transitions on accept SHALL be V0->V1 (store p), V1->V2 (store q), and V2->V0 (triangle complete).
REQ-019 On a V2 accept, the 2D signed area term A = (q.x-p.x)*(r.y-p.y) - (q.y-p.y)*(r.x-p.x) SHALL be computed combinationally from the held p, q and the incoming vertex r.
REQ-020 The operands of A SHALL be sign-extended to COORD_W+1 bits, the products SHALL be 2*COORD_W+2 bits, and A SHALL be 2*COORD_W+3 bits with no overflow possible.
REQ-021 If cull_en=1 and A==0, the triangle SHALL be dropped: tri_valid and tri_out unchanged, cull_count increments by 1.
REQ-022 Otherwise, the V2 accept SHALL load tri_out = {p, q, r} and set tri_valid on the next edge; latency is 1 cycle from the third accept to tri_valid.
REQ-023 tri_count SHALL increment on the cycle tri_out is loaded.
REQ-024 While tri_valid=1 and tri_ready=0, tri_out SHALL be held stable and no vertex SHALL be accepted (back-pressure).
REQ-025 When tri_valid and tri_ready are both high and no new triangle is loaded on that cycle, tri_valid SHALL clear on the next edge.
REQ-026 A simultaneous handshake and V2 accept SHALL keep tri_valid=1 with the new triangle loaded (full throughput, one triangle per 3 cycles).
REQ-027 flush=1 SHALL force the FSM to V0 on the next edge and SHALL accept no vertex that cycle (flush wins over vtx_valid).
REQ-028 flush SHALL NOT affect tri_valid, tri_out or the counters.
REQ-029 A culled triangle SHALL NOT require a free output slot, but acceptance SHALL still obey REQ-016.
REQ-030 Counters SHALL wrap from 2^CNT_W-1 to 0.
REQ-031 tri_count and cull_count SHALL NOT both increment on the same cycle.

Reset
REQ-032 n_rst=0 SHALL immediately and asynchronously set: FSM=V0, held vertices=0, tri_valid=0, tri_out=all zeros, tri_count=0, cull_count=0.
REQ-033 vtx_ready SHALL read 1 during and after reset unless flush=1.
REQ-034 Reset asserted mid-triangle SHALL discard all held vertices; the first vertex after reset release SHALL become p.
REQ-035 Reset asserted while tri_valid=1 SHALL drop the pending triangle without a handshake.

Verification
REQ-036 Bench: vertices (0,0,1), (10,0,2), (0,5,3) streamed back-to-back, tri_ready=1, cull_en=1 -> tri_valid=1 exactly one cycle after the 3rd accept; tri_out.p=(0,0,1), q=(10,0,2), r=(0,5,3); tri_count=1.
REQ-037 Bench: collinear vertices (0,0,0), (2,2,0), (4,4,0) with cull_en=1 -> tri_valid stays 0, cull_count=1, FSM back to V0; the same vertices with cull_en=0 -> triangle emitted, tri_count=1.
REQ-038 Bench: tri_ready=0 held for 5 cycles while 4 vertices are offered -> tri_out stable and vtx_ready=0 after the first triangle; on releasing tri_ready, the 4th vertex is accepted as the next p.
REQ-039 Bench: two vertices accepted, then flush=1 with vtx_valid=1 -> that vertex is not accepted; the next three vertices form a triangle with the post-flush first vertex as p.
REQ-040 Bench: n_rst pulsed low mid-clock with one vertex held and tri_valid=1 -> all outputs zero immediately; the next triangle uses only post-reset vertices.
REQ-041 Bench: extreme coordinates (-32768,-32768), (32767,-32768), (-32768,32767) -> A=4294836225, not culled; 65537 valid triangles -> tri_count wraps to 1.
